// File: rtl/alu_pkg.sv
// Shared ALU control encodings, MIPS opcode/func constants and immediate extension helpers.
// The ALU_OPERAND_VSHIFT_EN macro, consumed by alu_op_decode, enables sllv/srlv/srav.
package alu_pkg;

    typedef enum logic [3:0] {
        AluAdd     = 4'd0,
        AluSub     = 4'd1,
        AluAnd     = 4'd2,
        AluOr      = 4'd3,
        AluXor     = 4'd4,
        AluNor     = 4'd5,
        AluSlt     = 4'd6,
        AluSltu    = 4'd7,
        AluSll     = 4'd8,
        AluSrl     = 4'd9,
        AluSra     = 4'd10,
        AluInvalid = 4'd15
    } alu_op_e;

    // Operand-select code from the decoder to the top-level muxes
    typedef enum logic [2:0] {
        SelRegs,
        SelShamt,
        SelVshift,
        SelSext,
        SelZext,
        SelLui
    } opsel_e;

    localparam logic [5:0] OpRtype = 6'b000000;
    localparam logic [5:0] OpBeq   = 6'b000100;
    localparam logic [5:0] OpBne   = 6'b000101;
    localparam logic [5:0] OpAddi  = 6'b001000;
    localparam logic [5:0] OpAddiu = 6'b001001;
    localparam logic [5:0] OpSlti  = 6'b001010;
    localparam logic [5:0] OpSltiu = 6'b001011;
    localparam logic [5:0] OpAndi  = 6'b001100;
    localparam logic [5:0] OpOri   = 6'b001101;
    localparam logic [5:0] OpXori  = 6'b001110;
    localparam logic [5:0] OpLui   = 6'b001111;
    localparam logic [5:0] OpLw    = 6'b100011;
    localparam logic [5:0] OpSw    = 6'b101011;

    localparam logic [5:0] FnSll  = 6'b000000;
    localparam logic [5:0] FnSrl  = 6'b000010;
    localparam logic [5:0] FnSra  = 6'b000011;
    localparam logic [5:0] FnSllv = 6'b000100;
    localparam logic [5:0] FnSrlv = 6'b000110;
    localparam logic [5:0] FnSrav = 6'b000111;
    localparam logic [5:0] FnJr   = 6'b001000;
    localparam logic [5:0] FnAdd  = 6'b100000;
    localparam logic [5:0] FnAddu = 6'b100001;
    localparam logic [5:0] FnSub  = 6'b100010;
    localparam logic [5:0] FnSubu = 6'b100011;
    localparam logic [5:0] FnAnd  = 6'b100100;
    localparam logic [5:0] FnOr   = 6'b100101;
    localparam logic [5:0] FnXor  = 6'b100110;
    localparam logic [5:0] FnNor  = 6'b100111;
    localparam logic [5:0] FnSlt  = 6'b101010;
    localparam logic [5:0] FnSltu = 6'b101011;

    function automatic logic [31:0] sign_ext(input logic [15:0] imm);
        return {{16{imm[15]}}, imm};
    endfunction

    function automatic logic [31:0] zero_ext(input logic [15:0] imm);
        return {16'h0000, imm};
    endfunction

endpackage

// File: rtl/alu_operand_ctrl_if.sv
// Instruction fields and register values in, ALU control and operands out.
interface alu_operand_ctrl_if;

    logic        [5:0]  opcode;
    logic        [5:0]  func;
    logic        [4:0]  shamt;
    logic        [15:0] imm;
    logic signed [31:0] reg_A;
    logic signed [31:0] reg_B;
    logic        [3:0]  alu_op;
    logic signed [31:0] selected_A;
    logic signed [31:0] selected_B;

    // master: register-read side driving the stage; slave: the operand stage itself
    modport master (
        output opcode, func, shamt, imm, reg_A, reg_B,
        input  alu_op, selected_A, selected_B
    );

    modport slave (
        input  opcode, func, shamt, imm, reg_A, reg_B,
        output alu_op, selected_A, selected_B
    );

endinterface

// File: rtl/alu_op_decode.sv
// Combinational opcode/func decode to ALU operation and operand-select code.
// ALU_OPERAND_VSHIFT_EN enables sllv/srlv/srav; otherwise they decode as invalid.
module alu_op_decode
    import alu_pkg::*;
(
    input  logic [5:0] opcode,
    input  logic [5:0] func,
    output alu_op_e    alu_op,
    output opsel_e     sel
);

    always_comb begin
        alu_op = AluInvalid;
        sel    = SelRegs;
        if (opcode == OpRtype) begin
            case (func)
                FnAdd, FnAddu, FnJr: alu_op = AluAdd;
                FnSub, FnSubu:       alu_op = AluSub;
                FnAnd:               alu_op = AluAnd;
                FnOr:                alu_op = AluOr;
                FnXor:               alu_op = AluXor;
                FnNor:               alu_op = AluNor;
                FnSlt:               alu_op = AluSlt;
                FnSltu:              alu_op = AluSltu;
                FnSll: begin alu_op = AluSll; sel = SelShamt; end
                FnSrl: begin alu_op = AluSrl; sel = SelShamt; end
                FnSra: begin alu_op = AluSra; sel = SelShamt; end
`ifdef ALU_OPERAND_VSHIFT_EN
                FnSllv: begin alu_op = AluSll; sel = SelVshift; end
                FnSrlv: begin alu_op = AluSrl; sel = SelVshift; end
                FnSrav: begin alu_op = AluSra; sel = SelVshift; end
`endif
                default: alu_op = AluInvalid;
            endcase
        end else begin
            case (opcode)
                OpAddi, OpAddiu, OpLw, OpSw: begin alu_op = AluAdd;  sel = SelSext; end
                OpSlti:                      begin alu_op = AluSlt;  sel = SelSext; end
                OpSltiu:                     begin alu_op = AluSltu; sel = SelSext; end
                OpBeq, OpBne:                alu_op = AluSub;
                OpAndi:                      begin alu_op = AluAnd;  sel = SelZext; end
                OpOri:                       begin alu_op = AluOr;   sel = SelZext; end
                OpXori:                      begin alu_op = AluXor;  sel = SelZext; end
                OpLui:                       begin alu_op = AluSll;  sel = SelLui;  end
                default:                     alu_op = AluInvalid;
            endcase
        end
    end

endmodule

// File: rtl/alu_operand_ctrl.sv
// Registered ALU control and operand-select stage; all outputs appear one cycle after sampling.
// Build with ALU_OPERAND_VSHIFT_EN to decode variable shifts (handled in alu_op_decode).
module alu_operand_ctrl
    import alu_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    alu_operand_ctrl_if.slave bus
);

    alu_op_e     dec_op;
    opsel_e      dec_sel;
    logic [31:0] a_d, b_d;
    logic [3:0]  alu_op_q;
    logic [31:0] a_q, b_q;

    alu_op_decode u_decode (
        .opcode (bus.opcode),
        .func   (bus.func),
        .alu_op (dec_op),
        .sel    (dec_sel)
    );

    always_comb begin
        a_d = bus.reg_A;
        b_d = bus.reg_B;
        case (dec_sel)
            SelShamt:  begin a_d = bus.reg_B; b_d = {27'd0, bus.shamt};      end
            SelVshift: begin a_d = bus.reg_B; b_d = {27'd0, bus.reg_A[4:0]}; end
            SelSext:   b_d = sign_ext(bus.imm);
            SelZext:   b_d = zero_ext(bus.imm);
            // lui shifts the zero-extended immediate left by a fixed 16
            SelLui:    begin a_d = zero_ext(bus.imm); b_d = 32'd16; end
            default:   ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            alu_op_q <= 4'hF;
            a_q      <= '0;
            b_q      <= '0;
        end else begin
            alu_op_q <= dec_op;
            a_q      <= a_d;
            b_q      <= b_d;
        end
    end

    assign bus.alu_op     = alu_op_q;
    assign bus.selected_A = a_q;
    assign bus.selected_B = b_q;

endmodule

// File: tb/tb_alu_operand_ctrl.sv
// Directed self-checking bench for alu_operand_ctrl using hand-computed expected values.
module tb_alu_operand_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;

    alu_operand_ctrl_if bus ();

    alu_operand_ctrl dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic drive(input logic [5:0] op, input logic [5:0] fn, input logic [4:0] sh,
                         input logic [15:0] im, input logic [31:0] a, input logic [31:0] b);
        bus.opcode = op;
        bus.func   = fn;
        bus.shamt  = sh;
        bus.imm    = im;
        bus.reg_A  = a;
        bus.reg_B  = b;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [3:0] op, input logic [31:0] a,
                         input logic [31:0] b);
        logic [31:0] obs_a, obs_b;
        obs_a = bus.selected_A;
        obs_b = bus.selected_B;
        n_checks++;
        assert (bus.alu_op === op) else begin
            n_fail++;
            $error("FAIL %s alu_op: observed %0d expected %0d", tag, bus.alu_op, op);
        end
        n_checks++;
        assert (obs_a === a) else begin
            n_fail++;
            $error("FAIL %s selected_A: observed %h expected %h", tag, obs_a, a);
        end
        n_checks++;
        assert (obs_b === b) else begin
            n_fail++;
            $error("FAIL %s selected_B: observed %h expected %h", tag, obs_b, b);
        end
    endtask

    initial begin
        // Reset held for two cycles with live inputs
        drive(6'h00, 6'h20, 5'd3, 16'h1234, 32'h1111_1111, 32'h2222_2222);
        rst = 1'b1;
        step();
        step();
        check("reset", 4'd15, 32'h0, 32'h0);

        @(negedge clk);
        rst = 1'b0;
        drive(6'h00, 6'h20, 5'd0, 16'h0000, 32'd5, 32'hFFFF_FFFD);
        step();
        check("add", 4'd0, 32'd5, 32'hFFFF_FFFD);
        // Changing inputs between edges must not disturb the registered outputs
        drive(6'h00, 6'h22, 5'd0, 16'h0000, 32'd99, 32'd98);
        #2;
        check("hold", 4'd0, 32'd5, 32'hFFFF_FFFD);

        @(negedge clk);
        drive(6'h08, 6'h00, 5'd0, 16'hFFFE, 32'd7, 32'h55);
        step();
        check("addi", 4'd0, 32'd7, 32'hFFFF_FFFE);

        @(negedge clk);
        drive(6'h0D, 6'h00, 5'd0, 16'hFFFE, 32'd7, 32'h55);
        step();
        check("ori", 4'd3, 32'd7, 32'h0000_FFFE);

        @(negedge clk);
        drive(6'h0C, 6'h00, 5'd0, 16'h8001, 32'hFFFF_FFFF, 32'h55);
        step();
        check("andi", 4'd2, 32'hFFFF_FFFF, 32'h0000_8001);

        @(negedge clk);
        drive(6'h0A, 6'h00, 5'd0, 16'h8000, 32'd3, 32'h55);
        step();
        check("slti", 4'd6, 32'd3, 32'hFFFF_8000);

        @(negedge clk);
        drive(6'h00, 6'h03, 5'd4, 16'h0000, 32'h23, 32'h8000_0000);
        step();
        check("sra", 4'd10, 32'h8000_0000, 32'd4);

        @(negedge clk);
        drive(6'h00, 6'h00, 5'd31, 16'h0000, 32'h23, 32'd1);
        step();
        check("sll", 4'd8, 32'd1, 32'd31);

        @(negedge clk);
        drive(6'h00, 6'h07, 5'd4, 16'h0000, 32'h23, 32'h8000_0000);
        step();
`ifdef ALU_OPERAND_VSHIFT_EN
        check("srav", 4'd10, 32'h8000_0000, 32'd3);
`else
        check("srav", 4'd15, 32'h23, 32'h8000_0000);
`endif

        @(negedge clk);
        drive(6'h04, 6'h00, 5'd0, 16'h0010, 32'd9, 32'd9);
        step();
        check("beq", 4'd1, 32'd9, 32'd9);

        @(negedge clk);
        drive(6'h0F, 6'h00, 5'd0, 16'h1234, 32'hDEAD_BEEF, 32'h55);
        step();
        check("lui", 4'd8, 32'h0000_1234, 32'd16);

        @(negedge clk);
        drive(6'h00, 6'h08, 5'd0, 16'h0000, 32'h400, 32'h7);
        step();
        check("jr", 4'd0, 32'h400, 32'h7);

        @(negedge clk);
        drive(6'h3F, 6'h20, 5'd0, 16'h0000, 32'd1, 32'd2);
        step();
        check("bad_op", 4'd15, 32'd1, 32'd2);

        @(negedge clk);
        drive(6'h00, 6'h3F, 5'd0, 16'h0000, 32'd4, 32'd6);
        step();
        check("bad_fn", 4'd15, 32'd4, 32'd6);

        // Back-to-back add/sub, each output one cycle after its input
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (i % 2 == 0) drive(6'h00, 6'h20, 5'd0, 16'h0, 32'(i + 10), 32'(i + 20));
            else            drive(6'h00, 6'h22, 5'd0, 16'h0, 32'(i + 10), 32'(i + 20));
            step();
            check("b2b", (i % 2 == 0) ? 4'd0 : 4'd1, 32'(i + 10), 32'(i + 20));
        end

        @(negedge clk);
        rst = 1'b1;
        drive(6'h00, 6'h20, 5'd0, 16'h0, 32'd77, 32'd88);
        step();
        check("mid_rst", 4'd15, 32'h0, 32'h0);

        @(negedge clk);
        rst = 1'b0;
        step();
        check("post_rst", 4'd0, 32'd77, 32'd88);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
